// File: rtl/ft600_echo_checksum.sv
// rtl/ft600_echo_checksum.sv - packet loopback from RX FIFO to TX FIFO with appended 16-bit checksum
//
// Pops a header word, echoes it and hdr[LEN_W-1:0] payload words into the TX
// FIFO, then pushes the 16-bit wrapping sum of header and payload.
//
// Ports
//   clk        user clock, rising edge
//   rst        synchronous active-high reset
//   rx_en      RX FIFO pop strobe (registered)
//   rx_out     RX FIFO read data, head word presented while rx_en is high
//   rx_empty   RX FIFO empty
//   tx_en      TX FIFO push strobe (registered)
//   tx_in      TX FIFO write data (registered, held between pushes)
//   tx_full    TX FIFO full
//   busy       packet in progress
//   pkt_count  completed packets, wraps
//   led        pkt_count[7:0]

module ft600_echo_checksum #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             rx_en,
  input  logic [15:0]      rx_out,
  input  logic             rx_empty,
  output logic             tx_en,
  output logic [15:0]      tx_in,
  input  logic             tx_full,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [7:0]       led
);

  typedef enum logic [2:0] {
    HDR_RD  = 3'd0,
    HDR_CAP = 3'd1,
    HDR_WR  = 3'd2,
    PL_RD   = 3'd3,
    PL_CAP  = 3'd4,
    PL_WR   = 3'd5,
    CK_WR   = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // word holds whichever word is about to be echoed (header or payload)
  logic [15:0]      word;
  logic [15:0]      sum;
  logic [LEN_W-1:0] remaining;

  logic             rx_en_nxt;
  logic             tx_en_nxt;
  logic [15:0]      tx_in_nxt;
  logic             cap_hdr;
  logic             cap_pl;
  logic             ck_push;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR_RD;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      HDR_RD:  if (!rx_empty) state_nxt = HDR_CAP;
      HDR_CAP: state_nxt = HDR_WR;
      HDR_WR:  if (!tx_full) state_nxt = (remaining != '0) ? PL_RD : CK_WR;
      PL_RD:   if (!rx_empty) state_nxt = PL_CAP;
      PL_CAP:  state_nxt = PL_WR;
      PL_WR:   if (!tx_full) state_nxt = (remaining != '0) ? PL_RD : CK_WR;
      CK_WR:   if (!tx_full) state_nxt = HDR_RD;
      default: state_nxt = HDR_RD;
    endcase
  end

  // output / datapath control; strobes are computed here and registered below
  always_comb begin
    rx_en_nxt = 1'b0;
    tx_en_nxt = 1'b0;
    tx_in_nxt = tx_in;
    cap_hdr   = 1'b0;
    cap_pl    = 1'b0;
    ck_push   = 1'b0;
    case (state)
      HDR_RD, PL_RD: rx_en_nxt = !rx_empty;
      HDR_CAP:       cap_hdr = 1'b1;
      PL_CAP:        cap_pl = 1'b1;
      HDR_WR, PL_WR: begin
        if (!tx_full) begin
          tx_en_nxt = 1'b1;
          tx_in_nxt = word;
        end
      end
      CK_WR: begin
        if (!tx_full) begin
          tx_en_nxt = 1'b1;
          tx_in_nxt = sum;
          ck_push   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_en     <= 1'b0;
      tx_en     <= 1'b0;
      tx_in     <= '0;
      word      <= '0;
      sum       <= '0;
      remaining <= '0;
      pkt_count <= '0;
    end else begin
      rx_en <= rx_en_nxt;
      tx_en <= tx_en_nxt;
      tx_in <= tx_in_nxt;
      if (cap_hdr) begin
        word      <= rx_out;
        sum       <= rx_out;
        remaining <= rx_out[LEN_W-1:0];
      end
      if (cap_pl) begin
        word      <= rx_out;
        sum       <= sum + rx_out;
        remaining <= remaining - LEN_W'(1);
      end
      if (ck_push) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end
    end
  end

  assign busy = (state != HDR_RD);
  assign led  = pkt_count[7:0];

endmodule

// File: tb/tb_ft600_echo_checksum.sv
// tb/tb_ft600_echo_checksum.sv - self-checking bench for ft600_echo_checksum

module tb_ft600_echo_checksum;

  localparam int LEN_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_en;
  logic [15:0]      rx_out;
  logic             rx_empty;
  logic             tx_en;
  logic [15:0]      tx_in;
  logic             tx_full = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] pkt_count;
  logic [7:0]       led;

  ft600_echo_checksum #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .rx_out    (rx_out),
    .rx_empty  (rx_empty),
    .tx_en     (tx_en),
    .tx_in     (tx_in),
    .tx_full   (tx_full),
    .busy      (busy),
    .pkt_count (pkt_count),
    .led       (led)
  );

  always #5 clk = ~clk;

  // RX FIFO model: head word always visible, popped on a clock edge with rx_en
  logic [15:0] rx_mem [0:1023];
  int          rx_wr = 0;
  int          rx_rd = 0;
  // TX FIFO model: captures every pushed word
  logic [15:0] tx_mem [0:1023];
  int          tx_wr = 0;
  int          viol_rx = 0;
  int          viol_tx = 0;

  bit          stall_req = 1'b0;
  bit          rand_en = 1'b0;
  bit          want_full;

  int          errors = 0;
  int          checks = 0;
  int          exp_pkts = 0;
  logic [15:0] pl [$];

  assign rx_empty = (rx_rd == rx_wr);
  assign rx_out   = rx_mem[rx_rd[9:0]];

  always @(posedge clk) begin
    if (rx_en) begin
      if (rx_empty) viol_rx <= viol_rx + 1;
      else          rx_rd <= rx_rd + 1;
    end
    if (tx_en) begin
      if (tx_full) viol_tx <= viol_tx + 1;
      tx_mem[tx_wr[9:0]] <= tx_in;
      tx_wr <= tx_wr + 1;
    end
  end

  // full is only raised when no push is in flight, like a real FIFO that fills by pushes
  always @(negedge clk) begin
    want_full = stall_req || (rand_en && ($urandom_range(0, 3) == 0));
    if (!want_full)  tx_full = 1'b0;
    else if (!tx_en) tx_full = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [15:0] w);
    rx_mem[rx_wr[9:0]] = w;
    rx_wr = rx_wr + 1;
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (tx_wr < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " complete"}, 32'(tx_wr >= target), 32'd1);
  endtask

  // Expected TX stream is header, payload, then the mod-2^16 sum of all of them.
  task automatic run_pkt(input string tag, input logic [15:0] hdr, input int gap_max,
                         input int first_gap, input int stall);
    logic [15:0] exp_w [$];
    int          sum;
    int          base;
    int          n;
    int          frozen;
    base = tx_wr;
    sum  = int'(hdr);
    exp_w.push_back(hdr);
    foreach (pl[i]) begin
      sum = sum + int'(pl[i]);
      exp_w.push_back(pl[i]);
    end
    exp_w.push_back(sum[15:0]);
    push_rx(hdr);
    foreach (pl[i]) begin
      if (i == 0 && first_gap > 0) begin
        repeat (first_gap) @(negedge clk);
        check({tag, " stalled busy"}, 32'(busy), 32'd1);
        check({tag, " stalled tx count"}, 32'(tx_wr - base), 32'd1);
      end
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      push_rx(pl[i]);
    end
    if (stall > 0) begin
      n = 0;
      while (tx_wr == base && n < 200) begin
        @(negedge clk);
        n++;
      end
      stall_req = 1'b1;
      repeat (5) @(negedge clk);
      frozen = tx_wr;
      repeat (stall - 5) @(negedge clk);
      check({tag, " no push while full"}, 32'(tx_wr - frozen), 32'd0);
      stall_req = 1'b0;
    end
    wait_tx(base + exp_w.size(), 3000, tag);
    repeat (4) @(negedge clk);
    check({tag, " word count"}, 32'(tx_wr - base), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      check($sformatf("%s word%0d", tag, i), 32'(tx_mem[10'(base + i)]), 32'(exp_w[i]));
    end
    exp_pkts++;
    check({tag, " pkt_count"}, 32'(pkt_count), 32'(exp_pkts[CNT_W-1:0]));
    check({tag, " led"}, 32'(led), 32'(exp_pkts[7:0]));
    check({tag, " busy idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          len;
    int          base;
    int          n;
    logic [15:0] hdr;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset rx_en", 32'(rx_en), 32'd0);
    check("reset tx_en", 32'(tx_en), 32'd0);
    check("reset tx_in", 32'(tx_in), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pkt_count", 32'(pkt_count), 32'd0);
    check("reset led", 32'(led), 32'd0);

    // basic two-word packet: checksum 0x3335
    pl = '{16'h1111, 16'h2222};
    run_pkt("t1", 16'h0002, 0, 0, 0);
    // zero length: checksum equals header
    pl = '{};
    run_pkt("t2", 16'hAB00, 0, 0, 0);
    // checksum wraps to zero
    pl = '{16'hFFFF};
    run_pkt("t3", 16'h0001, 0, 0, 0);
    // TX full for 50 cycles during payload
    pl = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    run_pkt("t4", 16'h0004, 0, 0, 50);
    // RX empty for 100 cycles after the header
    pl = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
    run_pkt("t5", 16'h0003, 0, 100, 0);

    // random packets with random RX gaps and random TX back-pressure
    rand_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(0, 6);
      pl = '{};
      for (int i = 0; i < len; i++) pl.push_back(16'($urandom));
      hdr = {8'($urandom), 8'(len)};
      run_pkt($sformatf("rnd%0d", p), hdr, 2, 0, 0);
    end
    rand_en = 1'b0;
    repeat (3) @(negedge clk);

    // reset while a payload word waits in PL_WR
    base = tx_wr;
    push_rx(16'h0002);
    push_rx(16'h7777);
    n = 0;
    while (tx_wr == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6 header echoed", 32'(tx_mem[10'(base)]), 32'h0002);
    @(negedge clk);
    check("t6 busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6 rx_en", 32'(rx_en), 32'd0);
    check("t6 tx_en", 32'(tx_en), 32'd0);
    check("t6 tx_in", 32'(tx_in), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 pkt_count", 32'(pkt_count), 32'd0);
    check("t6 led", 32'(led), 32'd0);
    check("t6 payload not pushed", 32'(tx_wr - base), 32'd1);
    rst = 1'b0;
    exp_pkts = 0;
    @(negedge clk);
    pl = '{16'h0005};
    run_pkt("t6 after reset", 16'h0001, 0, 0, 0);

    check("rx_en while empty", 32'(viol_rx), 32'd0);
    check("tx_en while full", 32'(viol_tx), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
